// File: rtl/dvd_feed_pkg.sv
// -----------------------------------------------------------------------------
// dvd_feed_pkg
// Shared definitions for the divider-accelerator bus feeder:
//   - frame FSM state encodings (IDLE, B0..B3) as legacy localparams plus an
//     enum view of the same encodings for debug visibility
//   - FRAME_BYTES, the number of bytes per operand frame on the 8-bit bus
//   - BYTE_ORDER_MSB_FIRST, the byte order this block owns on the link
//   - operand_pair_t, the {dividend, divisor} pair stored in the FIFO
//   - pack_frame(), which orders a pair into the 32-bit frame word so that
//     bits [31:24] always carry the first byte on the bus
// -----------------------------------------------------------------------------
package dvd_feed_pkg;

   localparam int FRAME_BYTES = 4;

   // 1: dividend[15:8], dividend[7:0], divisor[15:8], divisor[7:0]
   localparam logic BYTE_ORDER_MSB_FIRST = 1'b1;

   localparam logic [2:0] FS_IDLE = 3'd0;
   localparam logic [2:0] FS_B0   = 3'd1;
   localparam logic [2:0] FS_B1   = 3'd2;
   localparam logic [2:0] FS_B2   = 3'd3;
   localparam logic [2:0] FS_B3   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = FS_IDLE,
      ST_B0   = FS_B0,
      ST_B1   = FS_B1,
      ST_B2   = FS_B2,
      ST_B3   = FS_B3
   } feed_state_e;

   typedef struct packed {
      logic [15:0] dividend;
      logic [15:0] divisor;
   } operand_pair_t;

   // Frame word with the first byte to transmit in bits [31:24].
   function automatic logic [31:0] pack_frame(input operand_pair_t pair);
      logic [31:0] word_s;
      word_s = {pair.dividend, pair.divisor};
      if (BYTE_ORDER_MSB_FIRST) begin
         pack_frame = word_s;
      end else begin
         pack_frame = {word_s[7:0], word_s[15:8], word_s[23:16], word_s[31:24]};
      end
   endfunction

endpackage

// File: rtl/dvd_feed_fifo.sv
// -----------------------------------------------------------------------------
// dvd_feed_fifo
// Synchronous FIFO with occupancy count. The head entry is presented
// combinationally on rd_data; rd_en pops it at the clock edge. Writes while
// full and reads while empty are ignored. A write at full is refused even if
// a read happens in the same cycle (no full-bypass).
// Ports:
//   clk      rising-edge clock
//   RstN     asynchronous active-low reset (pointers, count, storage cleared)
//   wr_en    write request, honoured when not full
//   wr_data  entry to write
//   rd_en    pop request, honoured when not empty
//   rd_data  head entry
//   count    entries stored (registered)
//   full     count == DEPTH
//   empty    count == 0
// -----------------------------------------------------------------------------
module dvd_feed_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             RstN,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   assign full    = (count_r == CNT_W'(DEPTH));
   assign empty   = (count_r == '0);
   assign push_s  = wr_en && !full;
   assign pop_s   = rd_en && !empty;
   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;

   // Storage array: written at the write pointer on an accepted push.
   always_ff @(posedge clk or negedge RstN) begin
      if (!RstN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge RstN) begin
      if (!RstN) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Occupancy: push+pop together leaves the count unchanged.
   always_ff @(posedge clk or negedge RstN) begin
      if (!RstN) begin
         count_r <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/dvd_bus_feeder.sv
// -----------------------------------------------------------------------------
// dvd_bus_feeder
// Buffers 16-bit dividend/divisor pairs from a producer and serializes each
// pair into a 4-byte frame on the divider accelerator's 8-bit input bus:
//   B0: dividend[15:8] (StartData=1), B1: dividend[7:0],
//   B2: divisor[15:8], B3: divisor[7:0], then at least one IDLE cycle.
// A frame is launched from IDLE only when the FIFO is non-empty and
// ReadyToAccept is high; once started it always completes.
// All bus outputs are registered.
// Ports:
//   clk            rising-edge clock
//   RstN           asynchronous active-low reset (aborts any frame)
//   PushValid      producer offers a pair
//   PushReady      FIFO not full (combinational from count only)
//   PushDividend   dividend of offered pair
//   PushDivisor    divisor of offered pair
//   ReadyToAccept  accelerator can take a new frame (sampled in IDLE only)
//   StartData      high on the cycle carrying byte 0 of a frame
//   BusDataIn      frame byte, 0 when idle
//   Busy           frame in progress (B0..B3)
//   DropCount      (DVD_FEED_ZERO_FILTER_EN only) saturating count of
//                  discarded zero-divisor pairs
//   Level          pairs currently stored
// Build option:
//   DVD_FEED_ZERO_FILTER_EN - when defined, a head pair with divisor==0 is
//   popped and discarded in IDLE (one cycle, independent of ReadyToAccept).
// -----------------------------------------------------------------------------
module dvd_bus_feeder
   import dvd_feed_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             RstN,
   input  logic             PushValid,
   output logic             PushReady,
   input  logic [15:0]      PushDividend,
   input  logic [15:0]      PushDivisor,
   input  logic             ReadyToAccept,
   output logic             StartData,
   output logic [7:0]       BusDataIn,
   output logic             Busy,
`ifdef DVD_FEED_ZERO_FILTER_EN
   output logic [7:0]       DropCount,
`endif
   output logic [LVL_W-1:0] Level
);

   operand_pair_t    push_pair_s;
   operand_pair_t    head_pair_s;
   logic [31:0]      head_word_s;
   logic [LVL_W-1:0] count_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             launch_s;
   logic             drop_s;
   logic             pop_s;

   logic [2:0]       state_r;
   logic [31:0]      shift_r;
   logic             start_r;
   logic [7:0]       bus_r;
   logic             busy_r;

   assign push_pair_s = '{dividend: PushDividend, divisor: PushDivisor};
   assign head_word_s = pack_frame(head_pair_s);

   dvd_feed_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(operand_pair_t)),
      .CNT_W (LVL_W)
   ) u_fifo (
      .clk     (clk),
      .RstN    (RstN),
      .wr_en   (PushValid),
      .wr_data (push_pair_s),
      .rd_en   (pop_s),
      .rd_data (head_pair_s),
      .count   (count_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   assign PushReady = !fifo_full_s;
   assign Level     = count_s;
   assign StartData = start_r;
   assign BusDataIn = bus_r;
   assign Busy      = busy_r;

   // Head-of-queue decision in IDLE: discard (filter build), launch, or wait.
   always_comb begin
      launch_s = 1'b0;
      drop_s   = 1'b0;
      if ((state_r == FS_IDLE) && !fifo_empty_s) begin
`ifdef DVD_FEED_ZERO_FILTER_EN
         if (head_pair_s.divisor == 16'h0000) begin
            drop_s = 1'b1;
         end else if (ReadyToAccept) begin
            launch_s = 1'b1;
         end else begin
            launch_s = 1'b0;
         end
`else
         if (ReadyToAccept) begin
            launch_s = 1'b1;
         end else begin
            launch_s = 1'b0;
         end
`endif
      end else begin
         launch_s = 1'b0;
         drop_s   = 1'b0;
      end
      pop_s = launch_s || drop_s;
   end

   // Frame FSM: byte 0 is loaded straight into the output register at launch,
   // the remaining three bytes stream out of the shift register.
   always_ff @(posedge clk or negedge RstN) begin
      if (!RstN) begin
         state_r <= FS_IDLE;
         shift_r <= 32'h0000_0000;
         start_r <= 1'b0;
         bus_r   <= 8'h00;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            FS_IDLE: begin
               if (launch_s) begin
                  state_r <= FS_B0;
                  shift_r <= {head_word_s[23:0], 8'h00};
                  bus_r   <= head_word_s[31:24];
                  start_r <= 1'b1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= FS_IDLE;
                  bus_r   <= 8'h00;
                  start_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            FS_B0, FS_B1, FS_B2: begin
               state_r <= state_r + 3'd1;
               bus_r   <= shift_r[31:24];
               shift_r <= {shift_r[23:0], 8'h00};
               start_r <= 1'b0;
               busy_r  <= 1'b1;
            end
            FS_B3: begin
               state_r <= FS_IDLE;
               shift_r <= 32'h0000_0000;
               bus_r   <= 8'h00;
               start_r <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= FS_IDLE;
               shift_r <= 32'h0000_0000;
               bus_r   <= 8'h00;
               start_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DVD_FEED_ZERO_FILTER_EN
   logic [7:0] drop_cnt_r;

   // Discard counter, saturating at 255.
   always_ff @(posedge clk or negedge RstN) begin
      if (!RstN) begin
         drop_cnt_r <= 8'h00;
      end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
         drop_cnt_r <= drop_cnt_r + 8'd1;
      end
   end

   assign DropCount = drop_cnt_r;
`endif

endmodule

// File: tb/tb_dvd_bus_feeder.sv
// -----------------------------------------------------------------------------
// tb_dvd_bus_feeder
// Table-driven bench for dvd_bus_feeder: per-cycle rows of {inputs, expected
// outputs} after each clock edge, plus hand-written sequences for reset
// mid-frame, pointer wrap with back-pressure, and zero-divisor handling.
// -----------------------------------------------------------------------------
module tb_dvd_bus_feeder;

   localparam int DEPTH = 4;
   localparam int LVL_W = 3;

   logic             clk = 1'b0;
   logic             RstN;
   logic             PushValid;
   logic             PushReady;
   logic [15:0]      PushDividend;
   logic [15:0]      PushDivisor;
   logic             ReadyToAccept;
   logic             StartData;
   logic [7:0]       BusDataIn;
   logic             Busy;
   logic [LVL_W-1:0] Level;
`ifdef DVD_FEED_ZERO_FILTER_EN
   logic [7:0]       DropCount;
`endif

   always #5 clk = ~clk;

   dvd_bus_feeder #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk           (clk),
      .RstN          (RstN),
      .PushValid     (PushValid),
      .PushReady     (PushReady),
      .PushDividend  (PushDividend),
      .PushDivisor   (PushDivisor),
      .ReadyToAccept (ReadyToAccept),
      .StartData     (StartData),
      .BusDataIn     (BusDataIn),
      .Busy          (Busy),
`ifdef DVD_FEED_ZERO_FILTER_EN
      .DropCount     (DropCount),
`endif
      .Level         (Level)
   );

   typedef struct {
      logic             pv;
      logic [15:0]      dd;
      logic [15:0]      ds;
      logic             rta;
      logic             e_pr;
      logic             e_sd;
      logic [7:0]       e_bus;
      logic             e_busy;
      logic [LVL_W-1:0] e_lvl;
   } vec_t;

   vec_t        tbl[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        cap_en   = 1'b0;
   logic [8:0]  cap_q[$];
   logic [31:0] exp_q[$];
   logic [15:0] w_dd[6];
   logic [15:0] w_ds[6];

   // Byte monitor: records {StartData, BusDataIn} for every busy cycle.
   always @(negedge clk) begin
      if (cap_en && Busy) cap_q.push_back({StartData, BusDataIn});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_row(input logic pv, input logic [15:0] dd, input logic [15:0] ds,
                          input logic rta, input logic pr, input logic sd,
                          input logic [7:0] bus, input logic busy, input logic [LVL_W-1:0] lvl);
      vec_t v;
      v.pv = pv; v.dd = dd; v.ds = ds; v.rta = rta;
      v.e_pr = pr; v.e_sd = sd; v.e_bus = bus; v.e_busy = busy; v.e_lvl = lvl;
      tbl.push_back(v);
   endtask

   // Launch edge then B1, B2, B3, and the return to IDLE; no pushes meanwhile.
   task automatic add_frame(input logic [15:0] dd, input logic [15:0] ds,
                            input logic rta, input logic [LVL_W-1:0] lvl);
      logic pr;
      pr = (lvl != LVL_W'(DEPTH));
      add_row(1'b0, 16'h0, 16'h0, rta, pr, 1'b1, dd[15:8], 1'b1, lvl);
      add_row(1'b0, 16'h0, 16'h0, rta, pr, 1'b0, dd[7:0],  1'b1, lvl);
      add_row(1'b0, 16'h0, 16'h0, rta, pr, 1'b0, ds[15:8], 1'b1, lvl);
      add_row(1'b0, 16'h0, 16'h0, rta, pr, 1'b0, ds[7:0],  1'b1, lvl);
      add_row(1'b0, 16'h0, 16'h0, rta, pr, 1'b0, 8'h00,    1'b0, lvl);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         PushValid     = tbl[i].pv;
         PushDividend  = tbl[i].dd;
         PushDivisor   = tbl[i].ds;
         ReadyToAccept = tbl[i].rta;
         step();
         check($sformatf("%s.r%0d.PushReady", name, i), {31'd0, PushReady}, {31'd0, tbl[i].e_pr});
         check($sformatf("%s.r%0d.StartData", name, i), {31'd0, StartData}, {31'd0, tbl[i].e_sd});
         check($sformatf("%s.r%0d.BusDataIn", name, i), {24'd0, BusDataIn}, {24'd0, tbl[i].e_bus});
         check($sformatf("%s.r%0d.Busy", name, i), {31'd0, Busy}, {31'd0, tbl[i].e_busy});
         check($sformatf("%s.r%0d.Level", name, i), 32'(Level), 32'(tbl[i].e_lvl));
      end
      tbl.delete();
      PushValid = 1'b0;
   endtask

   // Compare captured bytes against exp_q, frame by frame.
   task automatic check_frames(input string name);
      logic [31:0] word;
      logic [3:0]  flags;
      check($sformatf("%s.bytes", name), 32'(cap_q.size()), 32'(4 * exp_q.size()));
      for (int f = 0; f < exp_q.size(); f++) begin
         if (cap_q.size() >= 4 * (f + 1)) begin
            word  = {cap_q[4*f][7:0], cap_q[4*f+1][7:0], cap_q[4*f+2][7:0], cap_q[4*f+3][7:0]};
            flags = {cap_q[4*f][8], cap_q[4*f+1][8], cap_q[4*f+2][8], cap_q[4*f+3][8]};
            check($sformatf("%s.f%0d.data", name, f), word, exp_q[f]);
            check($sformatf("%s.f%0d.start", name, f), {28'd0, flags}, 32'h8);
         end
      end
      cap_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int guard;
      logic accepted;

      RstN = 1'b0; PushValid = 1'b0; PushDividend = 16'h0; PushDivisor = 16'h0;
      ReadyToAccept = 1'b0;
      step(); step();
      check("rst.PushReady", {31'd0, PushReady}, 32'd1);
      check("rst.StartData", {31'd0, StartData}, 32'd0);
      check("rst.BusDataIn", {24'd0, BusDataIn}, 32'd0);
      check("rst.Busy", {31'd0, Busy}, 32'd0);
      check("rst.Level", 32'(Level), 32'd0);
      RstN = 1'b1;
      step();

      // Single frame: byte order and launch latency.
      add_row(1'b1, 16'h1234, 16'h0056, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1);
      add_frame(16'h1234, 16'h0056, 1'b1, 3'd0);
      run_table("t1");

      // Fill to DEPTH with ReadyToAccept low, refuse a 5th, then drain in order.
      add_row(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1);
      add_row(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2);
      add_row(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3);
      add_row(1'b1, 16'h4444, 16'h0004, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd4);
      add_row(1'b1, 16'h5555, 16'h0005, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd4);
      add_frame(16'h1111, 16'h0001, 1'b1, 3'd3);
      add_frame(16'h2222, 16'h0002, 1'b1, 3'd2);
      add_frame(16'h3333, 16'h0003, 1'b1, 3'd1);
      add_frame(16'h4444, 16'h0004, 1'b1, 3'd0);
      add_row(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
      add_row(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
      run_table("t2");

      // ReadyToAccept dropped mid-frame: frame completes, next one waits.
      add_row(1'b1, 16'hA1B2, 16'hC3D4, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1);
      add_row(1'b1, 16'h0102, 16'h0304, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 3'd1);
      add_row(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 3'd1);
      add_row(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 3'd1);
      add_row(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 8'hD4, 1'b1, 3'd1);
      add_row(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1);
      add_row(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1);
      add_row(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1);
      add_frame(16'h0102, 16'h0304, 1'b1, 3'd0);
      run_table("t3");

      // Reset asserted during B2 with one pair still queued.
      add_row(1'b1, 16'hABCD, 16'h0003, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1);
      add_row(1'b1, 16'h1357, 16'h2468, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b1, 3'd1);
      add_row(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 8'hCD, 1'b1, 3'd1);
      add_row(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1);
      run_table("t4");
      #2 RstN = 1'b0;
      #1;
      check("t4.async.StartData", {31'd0, StartData}, 32'd0);
      check("t4.async.BusDataIn", {24'd0, BusDataIn}, 32'd0);
      check("t4.async.Busy", {31'd0, Busy}, 32'd0);
      check("t4.async.Level", 32'(Level), 32'd0);
      check("t4.async.PushReady", {31'd0, PushReady}, 32'd1);
      @(negedge clk);
      RstN = 1'b1;
      cap_q.delete();
      cap_en = 1'b1;
      repeat (8) step();
      cap_en = 1'b0;
      check("t4.after.bytes", 32'(cap_q.size()), 32'd0);
      check("t4.after.Busy", {31'd0, Busy}, 32'd0);
      cap_q.delete();

      // Push/pop in the same cycle at Level=2, then wrap the pointers.
      for (int i = 0; i < 6; i++) begin
         w_dd[i] = 16'hC000 + 16'(i * 16'h0111);
         w_ds[i] = 16'h0F00 + 16'(i);
      end
      ReadyToAccept = 1'b0;
      PushValid = 1'b1; PushDividend = w_dd[0]; PushDivisor = w_ds[0]; step();
      PushDividend = w_dd[1]; PushDivisor = w_ds[1]; step();
      check("t5.level2", 32'(Level), 32'd2);
      cap_en = 1'b1;
      ReadyToAccept = 1'b1;
      PushDividend = w_dd[2]; PushDivisor = w_ds[2]; step();
      check("t5.pushpop.Level", 32'(Level), 32'd2);
      check("t5.pushpop.Busy", {31'd0, Busy}, 32'd1);
      k = 3;
      guard = 0;
      while (k < 6 && guard < 100) begin
         PushValid = 1'b1; PushDividend = w_dd[k]; PushDivisor = w_ds[k];
         accepted = PushReady;
         step();
         if (accepted) k++;
         guard++;
      end
      PushValid = 1'b0;
      check("t5.pushes", 32'(k), 32'd6);
      guard = 0;
      while (!(Level == '0 && !Busy) && guard < 100) begin
         step();
         guard++;
      end
      check("t5.drain", {31'd0, (Level == '0 && !Busy)}, 32'd1);
      cap_en = 1'b0;
      for (int i = 0; i < 6; i++) exp_q.push_back({w_dd[i], w_ds[i]});
      check_frames("t5");

      // Zero-divisor pair followed by a normal pair.
      cap_en = 1'b1;
      ReadyToAccept = 1'b0;
      PushValid = 1'b1; PushDividend = 16'd100; PushDivisor = 16'd0; step();
      check("t6.level1", 32'(Level), 32'd1);
      PushDividend = 16'd100; PushDivisor = 16'd7; step();
`ifdef DVD_FEED_ZERO_FILTER_EN
      check("t6.filt.Level", 32'(Level), 32'd1);
      check("t6.filt.DropCount", 32'(DropCount), 32'd1);
      exp_q.push_back({16'd100, 16'd7});
`else
      check("t6.nofilt.Level", 32'(Level), 32'd2);
      exp_q.push_back({16'd100, 16'd0});
      exp_q.push_back({16'd100, 16'd7});
`endif
      PushValid = 1'b0;
      ReadyToAccept = 1'b1;
      repeat (14) step();
      cap_en = 1'b0;
      check("t6.end.Level", 32'(Level), 32'd0);
      check("t6.end.Busy", {31'd0, Busy}, 32'd0);
      check_frames("t6");
`ifdef DVD_FEED_ZERO_FILTER_EN
      check("t6.end.DropCount", 32'(DropCount), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
